stack_acq_engine: RTL and testbench

- Parametrised successor to the fixed signal/noise acquisition pair: a single stacking engine with run-time mode select (signal = trigger-locked stacking, noise = free-running decimated stacking).
- Strips leading samples, accumulates up to DEPTH points per scan over N scans into an internal signed accumulator RAM.
- Read back through a shifted, saturated OUT_W port for the DSP/host readout path.
- Runs entirely on clk_sys; the ADC sample strobe is already synchronised to clk_sys.

---
 rtl/stack_acq_if.sv | 43 ++++
 rtl/stack_acq_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_stack_acq_engine.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_acq_if.sv
// Handshake and config bundle for the stacking acquisition engine.
// Host/ADC side drives through master, the engine sits on slave.
interface stack_acq_if #(
  parameter int ADC_W = 12,
  parameter int AW    = 8,
  parameter int OUT_W = 16
);
  logic                    start;
  logic                    trig;
  logic                    adc_valid;
  logic [ADC_W-1:0]        adcdata;
  logic                    mode;
  logic [11:0]             strip_num;
  logic [AW:0]             acq_num;
  logic [3:0]              scan_num;
  logic [9:0]              div_num;
  logic [4:0]              shift;
  logic                    rd_addr_rst;
  logic                    rd_en;
  logic signed [OUT_W-1:0] dataout;
  logic                    data_valid;
  logic                    busy;
  logic                    done;
  logic                    sat;

  modport master (
    output start, trig, adc_valid, adcdata,
    output mode, strip_num, acq_num,
    output scan_num, div_num, shift,
    output rd_addr_rst, rd_en,
    input  dataout, data_valid,
    input  busy, done, sat
  );

  modport slave (
    input  start, trig, adc_valid, adcdata,
    input  mode, strip_num, acq_num,
    input  scan_num, div_num, shift,
    input  rd_addr_rst, rd_en,
    output dataout, data_valid,
    output busy, done, sat
  );
endinterface

// File: rtl/stack_acq_engine.sv
// Signal/noise stacking engine: strip, decimate, accumulate N scans
// into a signed RAM, then read back shifted and saturated.
module stack_acq_engine #(
  parameter int ADC_W = 12,
  parameter int DEPTH = 256,
  parameter int ACC_W = 20,
  parameter int OUT_W = 16
) (
  input logic        clk_sys,
  input logic        reset,
  stack_acq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HI_I = 2**(OUT_W-1) - 1;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(HI_I);
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A = '1;
  localparam logic [4:0] SH_MAX = 5'(ACC_W-1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_WAIT, S_STRIP,
    S_ACQ, S_FLUSH, S_DONE
  } state_t;

  state_t state, state_nx;

  logic              mode_q;
  logic [11:0]       strip_q;
  logic [AW-1:0]     last_q;
  logic [3:0]        scan_q;
  logic [9:0]        div_q;
  logic [4:0]        shift_q;

  logic [AW-1:0]     clr_cnt;
  logic [11:0]       strip_cnt;
  logic [9:0]        div_cnt;
  logic [AW-1:0]     pt;
  logic [3:0]        scan_cnt;
  logic [AW-1:0]     rd_ptr;

  logic              wr_pend;
  logic [AW-1:0]     wr_addr;
  logic signed [ACC_W-1:0] wr_samp;
  logic              rd_pend;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [ACC_W-1:0] mem [DEPTH];

  logic signed [ACC_W-1:0] sample;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]  clamp_val;
  logic              over, under;
  logic              accept, scan_end, last_scan;
  logic              strip_end, rd_go;
  logic [AW-1:0]     rd_addr, ram_ra, ram_wa;
  logic              ram_we;
  logic signed [ACC_W-1:0] ram_wd;
  logic [AW:0]       acq_m1;

  // Offset-binary to two's complement: flip MSB, sign-extend.
  assign sample = {{(ACC_W-ADC_W){~bus.adcdata[ADC_W-1]}},
                   ~bus.adcdata[ADC_W-1],
                   bus.adcdata[ADC_W-2:0]};

  assign accept    = (state == S_ACQ) && bus.adc_valid
                     && (div_cnt == '0);
  assign scan_end  = accept && (pt == last_q);
  assign last_scan = (scan_cnt + 4'd1) == scan_q;
  assign strip_end = (strip_q == '0) ||
                     (bus.adc_valid &&
                      strip_cnt == strip_q - 12'd1);
  assign rd_go     = (state == S_DONE) && bus.rd_en;
  assign rd_addr   = bus.rd_addr_rst ? '0 : rd_ptr;
  assign ram_ra    = (state == S_DONE) ? rd_addr : pt;
  assign acq_m1    = bus.acq_num - 1'b1;

  assign shifted   = acc_q >>> shift_q;
  assign over      = shifted > HI;
  assign under     = shifted < LO;
  assign clamp_val = over  ? HI[OUT_W-1:0] :
                     under ? LO[OUT_W-1:0] :
                     shifted[OUT_W-1:0];

  always_comb begin
    ram_we = 1'b0;
    ram_wa = wr_addr;
    ram_wd = acc_q + wr_samp;
    if (bus.start) begin
      ram_we = 1'b0;
    end else if (state == S_CLR) begin
      ram_we = 1'b1;
      ram_wa = clr_cnt;
      ram_wd = '0;
    end else if (wr_pend) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    acc_q <= mem[ram_ra];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_CLR: begin
        bus.busy = 1'b1;
        if (clr_cnt == LAST_A)
          state_nx = mode_q ? S_STRIP : S_WAIT;
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (bus.trig) state_nx = S_STRIP;
      end
      S_STRIP: begin
        bus.busy = 1'b1;
        if (strip_end) state_nx = S_ACQ;
      end
      S_ACQ: begin
        bus.busy = 1'b1;
        if (scan_end)
          state_nx = last_scan ? S_FLUSH :
                     mode_q ? S_STRIP : S_WAIT;
      end
      S_FLUSH: begin
        bus.busy = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE:  bus.done = 1'b1;
      default: state_nx = S_IDLE;
    endcase
    if (bus.start) state_nx = S_CLR;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_q    <= 1'b0;
      strip_q   <= '0;
      last_q    <= '0;
      scan_q    <= '0;
      div_q     <= '0;
      shift_q   <= '0;
      clr_cnt   <= '0;
      strip_cnt <= '0;
      div_cnt   <= '0;
      pt        <= '0;
      scan_cnt  <= '0;
      rd_ptr    <= '0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_samp   <= '0;
      rd_pend   <= 1'b0;
      bus.dataout    <= '0;
      bus.data_valid <= 1'b0;
      bus.sat        <= 1'b0;
    end else if (bus.start) begin
      mode_q  <= bus.mode;
      strip_q <= bus.strip_num;
      last_q  <= (bus.acq_num == '0 ||
                  bus.acq_num > DEPTH_V) ?
                 LAST_A : acq_m1[AW-1:0];
      scan_q  <= (bus.scan_num == '0) ?
                 4'd1 : bus.scan_num;
      div_q   <= bus.mode ? bus.div_num : '0;
      shift_q <= (bus.shift > SH_MAX) ?
                 SH_MAX : bus.shift;
      clr_cnt   <= '0;
      strip_cnt <= '0;
      div_cnt   <= '0;
      pt        <= '0;
      scan_cnt  <= '0;
      rd_ptr    <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.sat        <= 1'b0;
    end else begin
      wr_pend <= accept;
      wr_addr <= pt;
      wr_samp <= sample;
      rd_pend <= rd_go;
      bus.data_valid <= rd_pend;
      if (rd_pend) begin
        bus.dataout <= clamp_val;
        if (over || under) bus.sat <= 1'b1;
      end
      clr_cnt <= (state == S_CLR) ?
                 clr_cnt + 1'b1 : '0;
      if (state != S_STRIP)
        strip_cnt <= '0;
      else if (bus.adc_valid)
        strip_cnt <= strip_cnt + 12'd1;
      if (state != S_ACQ)
        div_cnt <= '0;
      else if (bus.adc_valid)
        div_cnt <= (div_cnt == div_q) ?
                   '0 : div_cnt + 10'd1;
      if (accept)
        pt <= scan_end ? '0 : pt + 1'b1;
      if (scan_end)
        scan_cnt <= scan_cnt + 4'd1;
      // Reset wins over a same-cycle read, which still reads 0.
      if (state == S_FLUSH)
        rd_ptr <= '0;
      else if (rd_go)
        rd_ptr <= (rd_addr == last_q) ?
                  '0 : rd_addr + 1'b1;
      else if (state == S_DONE && bus.rd_addr_rst)
        rd_ptr <= '0;
    end
  end
endmodule

// File: tb/tb_stack_acq_engine.sv
// Scoreboard bench for stack_acq_engine: per-point sums from a
// sample-list model, checked by a data_valid monitor.
module tb_stack_acq_engine;
  localparam int ADC_W = 12;
  localparam int DEPTH = 16;
  localparam int ACC_W = 20;
  localparam int OUT_W = 14;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_acq_if #(.ADC_W(ADC_W), .AW(AW), .OUT_W(OUT_W)) bus ();

  stack_acq_engine #(
    .ADC_W(ADC_W), .DEPTH(DEPTH),
    .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk_sys(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct { int val; int due; } exp_t;
  typedef struct {
    bit mode; int strip; int acq;
    int scan; int div; int shift;
  } cfg_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pat[$];
  int   model[DEPTH];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acq_eff, div_eff, scan_eff, sh_eff, rp;
  bit   sat_m;
  cfg_t c, c2;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int conv(int x);
    return x - (1 << (ADC_W-1));
  endfunction

  function automatic int wrapacc(int x);
    int m;
    m = x & ((1 << ACC_W) - 1);
    if (m >= (1 << (ACC_W-1))) m -= (1 << ACC_W);
    return m;
  endfunction

  function automatic int rd_model(int a);
    int v, hi, lo;
    v  = wrapacc(model[a]) >>> sh_eff;
    hi = (1 << (OUT_W-1)) - 1;
    lo = -(1 << (OUT_W-1));
    if (v > hi) begin v = hi; sat_m = 1'b1; end
    else if (v < lo) begin v = lo; sat_m = 1'b1; end
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected data_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("dataout", int'(bus.dataout), mon_e.val);
        chk("read latency", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(cfg_t k);
    bus.mode      = k.mode;
    bus.strip_num = 12'(k.strip);
    bus.acq_num   = (AW+1)'(k.acq);
    bus.scan_num  = 4'(k.scan);
    bus.div_num   = 10'(k.div);
    bus.shift     = 5'(k.shift);
    acq_eff  = (k.acq == 0 || k.acq > DEPTH) ? DEPTH : k.acq;
    scan_eff = (k.scan == 0) ? 1 : k.scan;
    div_eff  = k.mode ? k.div : 0;
    sh_eff   = (k.shift > ACC_W-1) ? ACC_W-1 : k.shift;
    foreach (model[i]) model[i] = 0;
    rp = 0;
    sat_m = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    // scramble config pins: the run must use the latched copy
    bus.mode      = 1'($urandom_range(0, 1));
    bus.strip_num = 12'($urandom_range(0, 4095));
    bus.acq_num   = (AW+1)'($urandom_range(0, 31));
    bus.scan_num  = 4'($urandom_range(0, 15));
    bus.div_num   = 10'($urandom_range(0, 1023));
    bus.shift     = 5'($urandom_range(0, 31));
    chk("busy after start", int'(bus.busy), 1);
    chk("done after start", int'(bus.done), 0);
  endtask

  task automatic send_scan(cfg_t k, int cap);
    int n, s;
    n = k.strip + (acq_eff - 1) * (div_eff + 1) + 1;
    if (cap >= 0 && cap < n) n = cap;
    repeat (2) tick();
    if (!k.mode) begin
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 2) == 0) tick();
      s = (pat.size() > 0) ? pat[i % pat.size()] :
          int'($urandom_range(0, 4095));
      bus.adcdata   = 12'(s);
      bus.adc_valid = 1'b1;
      bus.trig      = ($urandom_range(0, 4) == 0);
      bus.rd_en     = ($urandom_range(0, 7) == 0);
      if (i >= k.strip && (i - k.strip) % (div_eff + 1) == 0)
        model[(i - k.strip) / (div_eff + 1)] += conv(s);
      tick();
      bus.adc_valid = 1'b0;
      bus.trig      = 1'b0;
      bus.rd_en     = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic full_run(cfg_t k);
    int w;
    do_start(k);
    repeat (DEPTH + 2) tick();
    for (int s = 0; s < scan_eff; s++) send_scan(k, -1);
    w = 0;
    while (!bus.done && w < 20) begin
      tick();
      w++;
    end
    chk("done level", int'(bus.done), 1);
    chk("busy in done", int'(bus.busy), 0);
  endtask

  task automatic rd(bit rar);
    int a;
    exp_t e;
    a = rar ? 0 : rp;
    bus.rd_en = 1'b1;
    bus.rd_addr_rst = rar;
    e.val = rd_model(a);
    e.due = cyc + 2;
    sb.push_back(e);
    rp = (a == acq_eff - 1) ? 0 : a + 1;
    tick();
    bus.rd_en = 1'b0;
    bus.rd_addr_rst = 1'b0;
  endtask

  task automatic rand_reads(int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: tick();
        1: begin
          bus.rd_addr_rst = 1'b1;
          rp = 0;
          tick();
          bus.rd_addr_rst = 1'b0;
        end
        default: rd($urandom_range(0, 5) == 0);
      endcase
    end
  endtask

  task automatic finish_reads();
    repeat (4) tick();
    chk("scoreboard drained", sb.size(), 0);
    chk("sat flag", int'(bus.sat), int'(sat_m));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " dataout"}, int'(bus.dataout), 0);
    chk({tag, " data_valid"}, int'(bus.data_valid), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " done"}, int'(bus.done), 0);
    chk({tag, " sat"}, int'(bus.sat), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.trig = 1'b0;
    bus.adc_valid = 1'b0; bus.adcdata = '0;
    bus.mode = 1'b0; bus.strip_num = '0;
    bus.acq_num = '0; bus.scan_num = '0;
    bus.div_num = '0; bus.shift = '0;
    bus.rd_addr_rst = 1'b0; bus.rd_en = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // signal stack, then pointer reset and wrap
    pat = {'h7F0, 'h7F0, 'h801, 'h802, 'h803, 'h804};
    full_run('{1'b0, 2, 4, 3, 0, 0});
    repeat (3) rd(1'b0);
    rd(1'b1);
    repeat (5) rd(1'b0);
    finish_reads();

    // noise decimation
    pat = {'h801, 'h802, 'h803, 'h804, 'h805, 'h806};
    full_run('{1'b1, 0, 2, 1, 2, 0});
    repeat (2) rd(1'b0);
    finish_reads();

    // saturation edge: 4 x 2047 fits, 5 x 2047 clamps
    pat = {'hFFF};
    full_run('{1'b0, 0, 1, 4, 0, 0});
    rd(1'b0);
    finish_reads();
    full_run('{1'b0, 0, 1, 5, 0, 0});
    rd(1'b0);
    rd(1'b0);
    finish_reads();

    // negative value with shift
    pat = {'h7F8};
    full_run('{1'b0, 0, 1, 1, 0, 2});
    rd(1'b0);
    finish_reads();

    // read in flight then restart: no data_valid expected
    pat.delete();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    c = '{1'b1, 1, 8, 3, 1, 3};
    do_start(c);
    repeat (DEPTH + 2) tick();
    send_scan(c, 5);
    chk("busy mid-acq", int'(bus.busy), 1);
    c2 = '{1'b0, 1, 6, 2, 0, 1};
    full_run(c2);
    rand_reads(12);
    finish_reads();

    // reset mid-acquisition
    do_start(c);
    repeat (DEPTH + 2) tick();
    send_scan(c, 4);
    reset = 1'b1;
    tick();
    chk_zero("mid-acq reset");
    reset = 1'b0;
    tick();
    chk("idle after reset", int'(bus.busy), 0);

    for (int r = 0; r < 8; r++) begin
      c.mode  = 1'($urandom_range(0, 1));
      c.strip = $urandom_range(0, 3);
      c.acq   = $urandom_range(0, 2 * DEPTH - 1);
      c.scan  = $urandom_range(0, 5);
      c.div   = $urandom_range(0, 3);
      c.shift = $urandom_range(0, 23);
      full_run(c);
      rand_reads(20);
      finish_reads();
      if (r < 7 && $urandom_range(0, 1) == 1) begin
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
